// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle zx/nx/zy/ny/f/no function set plus a
// shift-and-add multiply, with valid/ready handshakes and registered flags.
module alu_mc #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_mul,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             no_q, no_d;

  logic [WIDTH-1:0] px, py, r_alu, acc_sum, res;
  logic             res_load, accept, mul_sel;

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == MUL);
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;

  always_comb begin
    px = zx ? '0 : x;
    if (nx) px = ~px;
    py = zy ? '0 : y;
    if (ny) py = ~py;
    accept  = in_valid && in_ready;
    mul_sel = op_mul && MUL_EN;
    r_alu   = f ? (px + py) : (px & py);
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    state_d  = state_q;
    out_d    = out_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    no_d     = no_q;
    res      = '0;
    res_load = 1'b0;

    case (state_q)
      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          res      = no_q ? ~acc_sum : acc_sum;
          res_load = 1'b1;
          state_d  = DONE;
        end
      end
      default: begin
        // IDLE and DONE share the accept path so DONE can hand off in one edge.
        if (state_q == DONE && out_ready) state_d = IDLE;
        if (accept) begin
          if (mul_sel) begin
            mcand_d  = px;
            mplier_d = py;
            acc_d    = '0;
            cnt_d    = '0;
            no_d     = no;
            state_d  = MUL;
          end else begin
            res      = no ? ~r_alu : r_alu;
            res_load = 1'b1;
            state_d  = DONE;
          end
        end
      end
    endcase

    if (res_load) begin
      out_d = res;
      zr_d  = (res == '0);
      ng_d  = res[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      out_q    <= '0;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      no_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      no_q     <= no_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=16: fixed vectors, random ops against a
// plain-arithmetic model, backpressure, back-to-back and reset sequences.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_mul = 1'b0;
  logic        zx = 1'b0, nx = 1'b0, zy = 1'b0, ny = 1'b0, f = 1'b0, no = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out;
  logic        zr, ng, busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  alu_mc #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_mul(op_mul), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x, y;
    logic [5:0]  ctl;
    logic        mul;
    logic [15:0] eo;
    logic        ezr, eng;
  } vec_t;

  vec_t tbl [9];

  // ctl = {zx, nx, zy, ny, f, no}
  function automatic logic [15:0] model(logic [15:0] a, logic [15:0] b, logic [5:0] c, logic m);
    logic [15:0] pa, pb, r;
    pa = c[5] ? 16'd0 : a;
    if (c[4]) pa = ~pa;
    pb = c[3] ? 16'd0 : b;
    if (c[2]) pb = ~pb;
    if (m) r = pa * pb;
    else   r = c[1] ? pa + pb : pa & pb;
    return c[0] ? ~r : r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c, input logic m);
    x = a; y = b; op_mul = m;
    {zx, nx, zy, ny, f, no} = c;
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c, input logic m);
    int n = 0;
    set_in(a, b, c, m);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input logic m, output int lat);
    int errs = 0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (m && (!busy || in_ready)) errs++;
      @(negedge clk);
      lat++;
    end
    if (m) chk("mul_busy_noready", errs, 0);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic full_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [5:0] c, input logic m);
    int lat;
    logic [15:0] e;
    e = model(a, b, c, m);
    issue(a, b, c, m);
    wait_result(m, lat);
    chk({name, "_lat"}, lat, m ? 17 : 1);
    chk({name, "_out"}, out, e);
    chk({name, "_flags"}, {zr, ng}, {(e == 16'd0), e[15]});
    release_out();
  endtask

  initial begin
    int lat;
    logic [15:0] hold_o;
    logic        hold_z, hold_n;
    int          errs;
    logic [15:0] exp_q[$];
    logic [15:0] bx, by;
    logic [5:0]  bc;

    tbl[0] = '{16'd5,     16'd3,     6'b000010, 1'b0, 16'd8,      1'b0, 1'b0};
    tbl[1] = '{16'd5,     16'd3,     6'b010011, 1'b0, 16'd2,      1'b0, 1'b0};
    tbl[2] = '{16'd5,     16'd3,     6'b111010, 1'b0, 16'hFFFF,   1'b0, 1'b1};
    tbl[3] = '{16'd5,     16'd3,     6'b101010, 1'b0, 16'd0,      1'b1, 1'b0};
    tbl[4] = '{16'd5,     16'd3,     6'b000000, 1'b0, 16'd1,      1'b0, 1'b0};
    tbl[5] = '{16'd5,     16'd3,     6'b001101, 1'b0, 16'hFFFA,   1'b0, 1'b1};
    tbl[6] = '{16'd7,     16'd6,     6'b000000, 1'b1, 16'd42,     1'b0, 1'b0};
    tbl[7] = '{16'h0100,  16'h0100,  6'b000000, 1'b1, 16'h0000,   1'b1, 1'b0};
    tbl[8] = '{16'hFFFF,  16'd2,     6'b000000, 1'b1, 16'hFFFE,   1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset_out", out, 16'd0);
    chk("reset_flags", {zr, ng, out_valid, busy, in_ready}, 5'b00001);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      issue(tbl[i].x, tbl[i].y, tbl[i].ctl, tbl[i].mul);
      wait_result(tbl[i].mul, lat);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].mul ? 17 : 1);
      chk($sformatf("tbl%0d_out", i), out, tbl[i].eo);
      chk($sformatf("tbl%0d_flags", i), {zr, ng}, {tbl[i].ezr, tbl[i].eng});
      release_out();
      chk($sformatf("tbl%0d_idle", i), {out_valid, in_ready}, 2'b01);
    end

    for (int i = 0; i < 40; i++) begin
      full_op($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom),
              6'($urandom_range(0, 63)), ($urandom_range(0, 3) == 0));
    end

    // Backpressure: result held for 5 cycles, then handoff on the release edge.
    issue(16'd9, 16'd4, 6'b010011, 1'b0);
    wait_result(1'b0, lat);
    hold_o = out; hold_z = zr; hold_n = ng;
    chk("bp_first", out, 16'd5);
    errs = 0;
    repeat (5) begin
      @(negedge clk);
      if (out !== hold_o || zr !== hold_z || ng !== hold_n || in_ready || !out_valid) errs++;
    end
    chk("bp_stable", errs, 0);
    set_in(16'h1234, 16'h0F0F, 6'b000000, 1'b0);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("bp_handoff_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp_handoff_valid", out_valid, 1'b1);
    chk("bp_handoff_out", out, 16'h0204);
    release_out();

    // Back-to-back ALU ops: one result per cycle.
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        chk($sformatf("b2b%0d_valid", i), out_valid, 1'b1);
        chk($sformatf("b2b%0d_out", i), out, exp_q.pop_front());
      end
      if (i < 6) begin
        bx = 16'($urandom); by = 16'($urandom);
        bc = 6'($urandom_range(0, 63));
        set_in(bx, by, bc, 1'b0);
        exp_q.push_back(model(bx, by, bc, 1'b0));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("b2b_drain", {out_valid, in_ready}, 2'b01);

    // Reset mid-multiply discards the partial product.
    issue(16'd300, 16'd77, 6'b000000, 1'b1);
    repeat (7) @(negedge clk);
    chk("rst_mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_out", out, 16'd0);
    chk("rst_mid_state", {out_valid, busy, zr, ng, in_ready}, 5'b00001);
    rst_n = 1'b1;
    @(negedge clk);
    full_op("post_rst", 16'd5, 16'd3, 6'b000010, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
